frota_memoria: RTL and testbench

Per-player fleet record store serving the collision checker. Holds two banks of 64-bit ship records (player 1, player 2), drives both banks combinationally at the checker's `addr`, and applies its `clear` write-backs. Each write-back decrements the ship's remaining-piece count, flags sunk ships, and tracks fleet destruction per player to declare end of game. A separate load port is used by the placement phase to write initial records.

---
 rtl/frota_pkg.sv | 42 ++++
 rtl/frota_banco.sv | 92 +++++++++
 rtl/frota_memoria.sv | 149 ++++++++++++++
 tb/tb_frota_memoria.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/frota_pkg.sv
// Shared record layout, field positions and ship type codes for the fleet store.
package frota_pkg;

   localparam int unsigned REC_W        = 64;
   localparam int unsigned DEPTH_PADRAO = 12;
   localparam int unsigned ADDR_W       = 5;
   localparam int unsigned N_SLOTS      = 5;
   localparam int unsigned SLOT_W       = 8;
   localparam int unsigned SLOT_MSB [N_SLOTS] = '{10, 18, 26, 34, 42};

   localparam int unsigned TIPO_MSB  = 2;
   localparam int unsigned TIPO_LSB  = 0;
   localparam int unsigned PAD_MSB   = 44;
   localparam int unsigned PAD_LSB   = 43;
   localparam int unsigned PECAS_MSB = 47;
   localparam int unsigned PECAS_LSB = 45;
   localparam int unsigned ZERO_MSB  = 63;
   localparam int unsigned ZERO_LSB  = 48;

   typedef enum logic [2:0] {
      TIPO_VAZIO        = 3'd0,
      TIPO_SUBMARINO    = 3'd1,
      TIPO_DESTROYER    = 3'd2,
      TIPO_CRUZADOR     = 3'd3,
      TIPO_ENCOURACADO  = 3'd4,
      TIPO_PORTA_AVIOES = 3'd5
   } tipo_navio_e;

   typedef logic [REC_W-1:0] registro_t;

   // Slots occupied in the stored record but cleared in the write-back image.
   function automatic logic [2:0] conta_acertos(registro_t antigo, registro_t novo);
      logic [2:0] k;
      k = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (antigo[SLOT_MSB[i] -: SLOT_W] != '0 && novo[SLOT_MSB[i] -: SLOT_W] == '0)
            k = k + 3'd1;
      end
      return k;
   endfunction

endpackage

// File: rtl/frota_banco.sv
// One player's record bank: combinational read, write-back piece accounting,
// placement load, and the live-ship counter for that bank.
module frota_banco
   import frota_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_PADRAO
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        addr,
   input  logic              wb_en,
   input  logic [63:0]       clear,
   input  logic              load_en,
   input  logic [4:0]        load_addr,
   input  logic [63:0]       load_data,
   output logic [63:0]       rdata,
   output logic              sink,
   output logic [2:0]        sink_tipo,
   output logic              hit,
   output logic [3:0]        navios
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   registro_t  mem_q [DEPTH];
   registro_t  mem_d [DEPTH];
   logic [3:0] navios_q, navios_d;

   logic             addr_ok, load_ok;
   logic [IDX_W-1:0] idx, lidx;
   registro_t        rec, novo;
   logic [2:0]       k, pecas_old, pecas_new, pecas_ld_old, pecas_ld_new;

   assign addr_ok = addr < DEPTH_A;
   assign load_ok = load_addr < DEPTH_A;
   assign idx     = addr[IDX_W-1:0];
   assign lidx    = load_addr[IDX_W-1:0];

   always_comb begin
      rec          = addr_ok ? mem_q[idx] : '0;
      rdata        = rec;
      k            = conta_acertos(rec, clear);
      pecas_old    = rec[PECAS_MSB:PECAS_LSB];
      pecas_new    = (pecas_old > k) ? pecas_old - k : 3'd0;
      pecas_ld_old = load_ok ? mem_q[lidx][PECAS_MSB:PECAS_LSB] : 3'd0;
      pecas_ld_new = load_data[PECAS_MSB:PECAS_LSB];
      mem_d        = mem_q;
      navios_d     = navios_q;
      novo         = '0;
      sink         = 1'b0;
      sink_tipo    = rec[TIPO_MSB:TIPO_LSB];
      hit          = 1'b0;

      if (load_en) begin
         if (load_ok) begin
            novo                    = load_data;
            novo[ZERO_MSB:ZERO_LSB] = '0;
            mem_d[lidx]             = novo;
            if (pecas_ld_old == 3'd0 && pecas_ld_new != 3'd0 && navios_q != 4'd15)
               navios_d = navios_q + 4'd1;
            else if (pecas_ld_old != 3'd0 && pecas_ld_new == 3'd0 && navios_q != 4'd0)
               navios_d = navios_q - 4'd1;
         end
      end else if (wb_en && addr_ok) begin
         novo                      = clear;
         novo[PECAS_MSB:PECAS_LSB] = pecas_new;
         novo[PAD_MSB:PAD_LSB]     = '0;
         novo[ZERO_MSB:ZERO_LSB]   = '0;
         mem_d[idx]                = novo;
         hit                       = (k != 3'd0);
         if (pecas_old != 3'd0 && pecas_new == 3'd0) begin
            sink = 1'b1;
            if (navios_q != 4'd0)
               navios_d = navios_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         navios_q <= '0;
      end else begin
         mem_q    <= mem_d;
         navios_q <= navios_d;
      end
   end

   assign navios = navios_q;

endmodule

// File: rtl/frota_memoria.sv
// Fleet record store: two banks, write precedence, sink pulse and end-of-game latch.
// Optional hit counters are built when FROTA_ESTATISTICA_EN is defined.
module frota_memoria
   import frota_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_PADRAO
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  addr,
   output logic [63:0] memoriaP1,
   output logic [63:0] memoriaP2,
   input  logic        wrep1,
   input  logic        wrep2,
   input  logic [63:0] clear,
   input  logic        load_en,
   input  logic        load_jogador,
   input  logic [4:0]  load_addr,
   input  logic [63:0] load_data,
   output logic        afundou,
   output logic        afundou_jogador,
   output logic [2:0]  afundou_tipo,
   output logic [3:0]  navios_p1,
   output logic [3:0]  navios_p2,
   output logic        fim_jogo,
   output logic        vencedor,
   output logic [7:0]  acertos_p1,
   output logic [7:0]  acertos_p2
);

   logic       wb1, wb2, ld1, ld2;
   logic       sink1, sink2, hit1, hit2;
   logic [2:0] tipo1, tipo2;

   logic       afundou_q, afundou_d;
   logic       afundou_jogador_q, afundou_jogador_d;
   logic [2:0] afundou_tipo_q, afundou_tipo_d;
   logic       fim_jogo_q, fim_jogo_d;
   logic       vencedor_q, vencedor_d;

   // Load wins over any write-back; bank 1 write-back wins over bank 2.
   assign wb1 = wrep1 & ~load_en & ~fim_jogo_q;
   assign wb2 = wrep2 & ~wrep1 & ~load_en & ~fim_jogo_q;
   assign ld1 = load_en & ~load_jogador;
   assign ld2 = load_en & load_jogador;

   frota_banco #(.DEPTH(DEPTH)) u_banco1 (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .wb_en     (wb1),
      .clear     (clear),
      .load_en   (ld1),
      .load_addr (load_addr),
      .load_data (load_data),
      .rdata     (memoriaP1),
      .sink      (sink1),
      .sink_tipo (tipo1),
      .hit       (hit1),
      .navios    (navios_p1)
   );

   frota_banco #(.DEPTH(DEPTH)) u_banco2 (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .wb_en     (wb2),
      .clear     (clear),
      .load_en   (ld2),
      .load_addr (load_addr),
      .load_data (load_data),
      .rdata     (memoriaP2),
      .sink      (sink2),
      .sink_tipo (tipo2),
      .hit       (hit2),
      .navios    (navios_p2)
   );

   always_comb begin
      afundou_d         = sink1 | sink2;
      afundou_jogador_d = ~sink1 & sink2;
      afundou_tipo_d    = sink1 ? tipo1 : (sink2 ? tipo2 : 3'd0);
      fim_jogo_d        = fim_jogo_q;
      vencedor_d        = vencedor_q;
      // A sink while the bank holds at most one live ship empties it.
      if (!fim_jogo_q) begin
         if (sink1 && navios_p1 <= 4'd1) begin
            fim_jogo_d = 1'b1;
            vencedor_d = 1'b1;
         end else if (sink2 && navios_p2 <= 4'd1) begin
            fim_jogo_d = 1'b1;
            vencedor_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         afundou_q         <= 1'b0;
         afundou_jogador_q <= 1'b0;
         afundou_tipo_q    <= '0;
         fim_jogo_q        <= 1'b0;
         vencedor_q        <= 1'b0;
      end else begin
         afundou_q         <= afundou_d;
         afundou_jogador_q <= afundou_jogador_d;
         afundou_tipo_q    <= afundou_tipo_d;
         fim_jogo_q        <= fim_jogo_d;
         vencedor_q        <= vencedor_d;
      end
   end

   assign afundou         = afundou_q;
   assign afundou_jogador = afundou_jogador_q;
   assign afundou_tipo    = afundou_tipo_q;
   assign fim_jogo        = fim_jogo_q;
   assign vencedor        = vencedor_q;

`ifdef FROTA_ESTATISTICA_EN
   logic [7:0] acertos_p1_q, acertos_p1_d;
   logic [7:0] acertos_p2_q, acertos_p2_d;

   always_comb begin
      acertos_p1_d = acertos_p1_q;
      acertos_p2_d = acertos_p2_q;
      if (hit1 && acertos_p1_q != 8'hFF) acertos_p1_d = acertos_p1_q + 8'd1;
      if (hit2 && acertos_p2_q != 8'hFF) acertos_p2_d = acertos_p2_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acertos_p1_q <= '0;
         acertos_p2_q <= '0;
      end else begin
         acertos_p1_q <= acertos_p1_d;
         acertos_p2_q <= acertos_p2_d;
      end
   end

   assign acertos_p1 = acertos_p1_q;
   assign acertos_p2 = acertos_p2_q;
`else
   logic unused_hits;
   assign unused_hits = hit1 ^ hit2;
   assign acertos_p1  = '0;
   assign acertos_p2  = '0;
`endif

endmodule

// File: tb/tb_frota_memoria.sv
// Directed vector bench for frota_memoria: table of single-cycle transactions
// followed by a hand-written read-latency sequence.
module tb_frota_memoria;

`ifdef FROTA_ESTATISTICA_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  addr;
   logic [63:0] memoriaP1, memoriaP2;
   logic        wrep1, wrep2;
   logic [63:0] clear;
   logic        load_en, load_jogador;
   logic [4:0]  load_addr;
   logic [63:0] load_data;
   logic        afundou, afundou_jogador;
   logic [2:0]  afundou_tipo;
   logic [3:0]  navios_p1, navios_p2;
   logic        fim_jogo, vencedor;
   logic [7:0]  acertos_p1, acertos_p2;

   int total = 0;
   int bad   = 0;

   frota_memoria #(.DEPTH(12)) dut (
      .clk             (clk),
      .rst             (rst),
      .addr            (addr),
      .memoriaP1       (memoriaP1),
      .memoriaP2       (memoriaP2),
      .wrep1           (wrep1),
      .wrep2           (wrep2),
      .clear           (clear),
      .load_en         (load_en),
      .load_jogador    (load_jogador),
      .load_addr       (load_addr),
      .load_data       (load_data),
      .afundou         (afundou),
      .afundou_jogador (afundou_jogador),
      .afundou_tipo    (afundou_tipo),
      .navios_p1       (navios_p1),
      .navios_p2       (navios_p2),
      .fim_jogo        (fim_jogo),
      .vencedor        (vencedor),
      .acertos_p1      (acertos_p1),
      .acertos_p2      (acertos_p2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, le, lj;
      logic [4:0]  la;
      logic [63:0] ld;
      logic [4:0]  addr;
      logic        w1, w2;
      logic [63:0] clr;
      logic [63:0] p1, p2;
      logic        af, aj;
      logic [2:0]  at;
      logic [3:0]  n1, n2;
      logic        fim, ven;
      logic [7:0]  a1, a2;
   } vec_t;

   vec_t vecs [$];

   function automatic logic [63:0] rec(input logic [2:0] t, input logic [7:0] s0, s1, s2, s3, s4,
                                       input logic [2:0] p);
      logic [63:0] r;
      r        = '0;
      r[2:0]   = t;
      r[10:3]  = s0;
      r[18:11] = s1;
      r[26:19] = s2;
      r[34:27] = s3;
      r[42:35] = s4;
      r[47:45] = p;
      return r;
   endfunction

   task automatic add(input logic r, le, lj, input logic [4:0] la, input logic [63:0] ld,
                      input logic [4:0] a, input logic w1, w2, input logic [63:0] clr,
                      input logic [63:0] p1, p2, input logic af, aj, input logic [2:0] at,
                      input logic [3:0] n1, n2, input logic fim, ven, input logic [7:0] a1, a2);
      vec_t v;
      v.rst = r;  v.le = le; v.lj = lj; v.la = la; v.ld = ld;
      v.addr = a; v.w1 = w1; v.w2 = w2; v.clr = clr;
      v.p1 = p1;  v.p2 = p2; v.af = af; v.aj = aj; v.at = at;
      v.n1 = n1;  v.n2 = n2; v.fim = fim; v.ven = ven;
      v.a1 = STAT ? a1 : 8'd0;
      v.a2 = STAT ? a2 : 8'd0;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input int i, input vec_t v);
      string t;
      t = $sformatf("v%0d", i);
      chk({t, " memoriaP1"}, memoriaP1, v.p1);
      chk({t, " memoriaP2"}, memoriaP2, v.p2);
      chk({t, " afundou"}, 64'(afundou), 64'(v.af));
      if (v.af) begin
         chk({t, " afundou_jogador"}, 64'(afundou_jogador), 64'(v.aj));
         chk({t, " afundou_tipo"}, 64'(afundou_tipo), 64'(v.at));
      end
      chk({t, " navios_p1"}, 64'(navios_p1), 64'(v.n1));
      chk({t, " navios_p2"}, 64'(navios_p2), 64'(v.n2));
      chk({t, " fim_jogo"}, 64'(fim_jogo), 64'(v.fim));
      if (v.fim) chk({t, " vencedor"}, 64'(vencedor), 64'(v.ven));
      chk({t, " acertos_p1"}, 64'(acertos_p1), 64'(v.a1));
      chk({t, " acertos_p2"}, 64'(acertos_p2), 64'(v.a2));
   endtask

   task automatic idle();
      rst = 1'b0; wrep1 = 1'b0; wrep2 = 1'b0; load_en = 1'b0;
   endtask

   logic [63:0] ra, rb, rc, rd, re, junk, z;

   initial begin
      ra   = rec(3, 8'h11, 8'h12, 8'h13, 0, 0, 3);
      rb   = rec(2, 8'h21, 8'h22, 8'h23, 0, 0, 3);
      rc   = rec(1, 8'h31, 0, 0, 0, 0, 1);
      rd   = rec(4, 8'h41, 0, 0, 0, 0, 1);
      re   = rec(5, 8'h51, 8'h52, 0, 0, 0, 2);
      junk = 64'hFFFF_1800_0000_0000;
      z    = '0;

      //  rst le lj la  ld   addr w1 w2 clr                                  p1                          p2                          af aj at n1 n2 fim ven a1 a2
      add(0, 1, 0, 0,  ra, 0,  0, 0, z,                                   ra,                         z,                          0, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 1, 1,  rb, 1,  0, 0, z,                                   z,                          rb,                         0, 0, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 1, 2,  rc, 2,  0, 0, z,                                   z,                          rc,                         0, 0, 0, 1, 2, 0, 0, 0, 0);
      add(0, 1, 0, 3,  rd, 3,  0, 0, z,                                   rd,                         z,                          0, 0, 0, 2, 2, 0, 0, 0, 0);
      add(0, 0, 0, 0,  z,  0,  1, 0, rec(3, 0, 8'h12, 8'h13, 0, 0, 3),    rec(3, 0, 8'h12, 8'h13, 0, 0, 2), z,                    0, 0, 0, 2, 2, 0, 0, 1, 0);
      add(0, 0, 0, 0,  z,  0,  1, 0, rec(3, 0, 8'h12, 8'h13, 0, 0, 3),    rec(3, 0, 8'h12, 8'h13, 0, 0, 2), z,                    0, 0, 0, 2, 2, 0, 0, 1, 0);
      add(0, 0, 0, 0,  z,  0,  1, 1, rec(3, 0, 8'h12, 8'h13, 0, 0, 7) | junk, rec(3, 0, 8'h12, 8'h13, 0, 0, 2), z,                0, 0, 0, 2, 2, 0, 0, 1, 0);
      add(0, 1, 1, 4,  re, 1,  0, 1, rec(2, 0, 8'h22, 8'h23, 0, 0, 3),    z,                          rb,                         0, 0, 0, 2, 3, 0, 0, 1, 0);
      add(0, 1, 1, 12, rc, 4,  0, 0, z,                                   z,                          re,                         0, 0, 0, 2, 3, 0, 0, 1, 0);
      add(0, 0, 0, 0,  z,  12, 1, 0, junk | 64'h7,                        z,                          z,                          0, 0, 0, 2, 3, 0, 0, 1, 0);
      add(0, 0, 0, 0,  z,  1,  0, 1, rec(2, 0, 8'h22, 8'h23, 0, 0, 3),    z,                          rec(2, 0, 8'h22, 8'h23, 0, 0, 2), 0, 0, 0, 2, 3, 0, 0, 1, 1);
      add(0, 0, 0, 0,  z,  2,  0, 1, rec(1, 0, 0, 0, 0, 0, 1),            z,                          rec(1, 0, 0, 0, 0, 0, 0),   1, 1, 1, 2, 2, 0, 0, 1, 2);
      add(0, 0, 0, 0,  z,  1,  0, 1, rec(2, 0, 0, 8'h23, 0, 0, 0),        z,                          rec(2, 0, 0, 8'h23, 0, 0, 1), 0, 0, 0, 2, 2, 0, 0, 1, 3);
      add(0, 0, 0, 0,  z,  3,  1, 0, rec(4, 0, 0, 0, 0, 0, 1),            rec(4, 0, 0, 0, 0, 0, 0),   z,                          1, 0, 4, 1, 2, 0, 0, 2, 3);
      add(0, 0, 0, 0,  z,  0,  1, 0, rec(3, 0, 0, 0, 0, 0, 2),            rec(3, 0, 0, 0, 0, 0, 0),   z,                          1, 0, 3, 0, 2, 1, 1, 3, 3);
      add(0, 0, 0, 0,  z,  1,  0, 1, z,                                   z,                          rec(2, 0, 0, 8'h23, 0, 0, 1), 0, 0, 0, 0, 2, 1, 1, 3, 3);
      add(0, 1, 1, 6,  rd, 6,  0, 0, z,                                   z,                          rd,                         0, 0, 0, 0, 3, 1, 1, 3, 3);
      add(0, 1, 1, 6,  z,  6,  0, 0, z,                                   z,                          z,                          0, 0, 0, 0, 2, 1, 1, 3, 3);
      add(1, 1, 0, 0,  ra, 0,  1, 0, z,                                   z,                          z,                          0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0,  z,  1,  0, 0, z,                                   z,                          z,                          0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0,  ra, 0,  0, 0, z,                                   ra,                         z,                          0, 0, 0, 1, 0, 0, 0, 0, 0);

      idle();
      rst = 1'b1; addr = '0; clear = '0; load_jogador = 1'b0; load_addr = '0; load_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset memoriaP1", memoriaP1, 64'd0);
      chk("reset memoriaP2", memoriaP2, 64'd0);
      chk("reset afundou", 64'(afundou), 64'd0);
      chk("reset navios", 64'({navios_p1, navios_p2}), 64'd0);
      chk("reset fim_vencedor", 64'({fim_jogo, vencedor}), 64'd0);
      chk("reset acertos", 64'({acertos_p1, acertos_p2}), 64'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst          = vecs[i].rst;
         load_en      = vecs[i].le;
         load_jogador = vecs[i].lj;
         load_addr    = vecs[i].la;
         load_data    = vecs[i].ld;
         addr         = vecs[i].addr;
         wrep1        = vecs[i].w1;
         wrep2        = vecs[i].w2;
         clear        = vecs[i].clr;
         @(posedge clk);
         #1 idle();
         #1 chk_all(i, vecs[i]);
      end

      // Read path has no latency on addr, but a write shows only after its edge.
      @(negedge clk);
      load_en = 1'b1; load_jogador = 1'b0; load_addr = 5'd7; load_data = rc; addr = 5'd7;
      #1 chk("latency before edge", memoriaP1, 64'd0);
      @(posedge clk);
      #1 idle();
      #1 chk("latency after edge", memoriaP1, rc);
      chk("latency navios_p1", 64'(navios_p1), 64'd2);
      addr = 5'd0;
      #1 chk("addr switch read", memoriaP1, ra);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
